interrupt_arbiter: RTL
======================

# interrupt_arbiter

Collects interrupt requests from up to `NUM_SRC` peripheral sources, latches them as pending, picks one winner, and drives the single-bit `interrupt_signal` and ISR target address into the core's interrupt controller. Sits between the peripherals and the interrupt controller. Guarantees one ISR at a time (no nesting) and holds new grants until the core reports ISR return.

## Interface
- `NUM_SRC`, 4: number of request sources (2..8)
- `ISR_BASE`, 12'h200: ISR address of source 0 (12-bit instruction memory address)
- `ISR_STRIDE`, 12'h020: address spacing between consecutive source ISRs

- `clk`  in  1  system clock, all logic on rising edge
- `nrst`  in  1  reset, synchronous, active-low
- `irq_req`  in  NUM_SRC  raw request lines, rising-edge triggered
- `irq_mask`  in  NUM_SRC  1 = source enabled
- `irq_en`  in  1  global interrupt enable
- `core_ready`  in  1  pipeline can accept an interrupt this cycle (no flush/stall in progress)
- `ret_isr`  in  1  one-cycle pulse from the interrupt controller when URET retires
- `interrupt_signal`  out  1  one-cycle request pulse to the interrupt controller
- `isr_addr`  out  12  ISR_BASE + irq_id*ISR_STRIDE, valid while `busy`
- `irq_id`  out  3  index of granted source
- `busy`  out  1  ISR in flight (states FIRE, SERVICE, COOLDOWN)
- `pending`  out  NUM_SRC  latched pending bits

## Operation
- Edge detect: `irq_prev` registers `irq_req`. Pending bit i sets when `irq_req[i] & ~irq_prev[i]`, independent of mask. Masked sources stay pending until unmasked.
- Eligible vector = `pending & irq_mask`, gated by `irq_en`.
- Priority: fixed, lowest index wins.
- FSM states:
  - IDLE: if eligible != 0 and `core_ready`, latch winner into `irq_id` and go to FIRE. Otherwise stay.
  - FIRE: `interrupt_signal`=1 for this cycle only. Clear `pending[irq_id]`. Go to SERVICE.
  - SERVICE: wait for `ret_isr`, then go to COOLDOWN. New edges still set pending; no grants are issued.
  - COOLDOWN: one cycle so the URET drains the pipeline, then go to IDLE.
- `ret_isr` is ignored outside SERVICE.
- Set/clear collision: a new edge on the source being cleared in FIRE leaves the bit set (set wins).
- `irq_en` or mask dropping after FIRE does not abort the ISR.
- `isr_addr` is computed in 12-bit arithmetic and wraps modulo 4096. This is the integrator's responsibility; no saturation.

## Timing
- Reset (`nrst`=0 at a clock edge): state IDLE, `pending`=0, `irq_prev`=0, `irq_id`=0, `interrupt_signal`=0, `busy`=0, `isr_addr`=ISR_BASE.
- Reset mid-ISR returns to IDLE immediately and discards all pending bits.
- Request edge sampled at edge N: pending visible after N. Earliest FIRE is after N+1; `interrupt_signal` is high during cycle N+2. Latency is 2 cycles from a sampled edge to the pulse.
- `irq_id` and `isr_addr` are stable from the FIRE cycle until IDLE is re-entered.
- Minimum spacing between two `interrupt_signal` pulses: FIRE + SERVICE(≥1) + COOLDOWN + IDLE(1) = 4 cycles.
- All outputs are registered except `isr_addr` (combinational from `irq_id`) and `busy` (decoded from state).

## Configuration
- `IRQ_ROUND_ROBIN_EN` defined:
  - Priority is round-robin. A `last_id` register (reset 0) records each grant.
  - The search starts at `last_id+1` and wraps at NUM_SRC.
- Not defined:
  - Fixed lowest-index priority; no `last_id` register.

## Test plan
- Reset then single edge: nrst released, `irq_mask`=4'b1111, `irq_en`=1, `core_ready`=1, rise on `irq_req[2]` -> `interrupt_signal` 1 cycle at N+2, `irq_id`=2, `isr_addr`=12'h240, `pending[2]` cleared.
- Simultaneous edges on sources 1 and 3 -> grant 1 first; after `ret_isr` and COOLDOWN, grant 3 (`isr_addr`=12'h260). With `IRQ_ROUND_ROBIN_EN` and `last_id`=1, source 3 still follows; repeat with sources 0 and 3 pending -> 3 before 0.
- Masked pending: edge on source 0 with `irq_mask[0]`=0 -> `pending`=4'b0001, no pulse. Set mask bit -> pulse 2 cycles later.
- `core_ready`=0 for 5 cycles with eligible pending -> no pulse. Pulse in the cycle after `core_ready` returns to 1.
- Edge on source 2 during SERVICE of source 2, plus spurious `ret_isr` in IDLE -> second ISR for 2 after COOLDOWN. Spurious pulse has no effect.
- `nrst`=0 during SERVICE with `pending`=4'b1010 -> next cycle: `busy`=0, `pending`=0, no pulse until a new edge.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: latches edge-triggered requests and grants one ISR at a time.
// Optional IRQ_ROUND_ROBIN_EN selects rotating priority instead of lowest-index.
module interrupt_arbiter #(
  parameter int          NUM_SRC    = 4,
  parameter logic [11:0] ISR_BASE   = 12'h200,
  parameter logic [11:0] ISR_STRIDE = 12'h020
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               irq_en,
  input  logic               core_ready,
  input  logic               ret_isr,
  output logic               interrupt_signal,
  output logic [11:0]        isr_addr,
  output logic [2:0]         irq_id,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    SERVICE,
    COOLDOWN
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] rise, elig, clr;
  logic [2:0]         id_q, id_d, win;
  logic               found;
  logic               int_q, int_d;
`ifdef IRQ_ROUND_ROBIN_EN
  logic [2:0]         last_q, last_d;
`endif

  // Pending bits: new edges set, the granted source clears in FIRE; set wins.
  always_comb begin
    rise = irq_req & ~prev_q;
    elig = irq_en ? (pend_q & irq_mask) : '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = (state_q == FIRE) && (id_q == 3'(i));
    end
    pend_d = (pend_q & ~clr) | rise;
  end

  // Winner search over the eligible vector.
  always_comb begin
    win   = '0;
    found = 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && elig[i] &&
            ((int'(last_q) + k) % NUM_SRC) == i) begin
          found = 1'b1;
          win   = 3'(i);
        end
      end
    end
`else
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && elig[i]) begin
        found = 1'b1;
        win   = 3'(i);
      end
    end
`endif
  end

  // Grant FSM: next state, latched id and request pulse.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    int_d   = 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found && core_ready) begin
          id_d    = win;
          int_d   = 1'b1;
          state_d = FIRE;
`ifdef IRQ_ROUND_ROBIN_EN
          last_d  = win;
`endif
        end
      end
      FIRE:     state_d = SERVICE;
      SERVICE:  if (ret_isr) state_d = COOLDOWN;
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      id_q    <= '0;
      int_q   <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= irq_req;
      pend_q  <= pend_d;
      id_q    <= id_d;
      int_q   <= int_d;
`ifdef IRQ_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign interrupt_signal = int_q;
  assign irq_id           = id_q;
  assign pending          = pend_q;
  assign busy             = (state_q != IDLE);
  assign isr_addr         = ISR_BASE + 12'(id_q) * ISR_STRIDE;

endmodule
